procn: RTL and testbench

Parametrised successor of the multi-cycle bus processor: N-bit datapath, eight general registers, one shared bus, external instruction words delivered on DIN under a Run/Done handshake. It adds logical ops, a compare, status flags (Z/Neg/C), illegal-opcode detection and a debug register read port. It sits where the fixed 16-bit processor sits; instruction memory/sequencing stays external.

---
 rtl/procn.sv | 183 ++++++++++++++++++
 tb/tb_procn.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procn.sv
// procn -- parametrised multi-cycle bus processor.
//
// N-bit datapath, eight general registers R0..R7, one shared bus, an
// accumulator-style A/G pair around the ALU and registered Z/Neg/C flags.
// Instruction words arrive on DIN and are accepted in T0 when Run is high.
// Sequencing and instruction memory are external.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous, active-high; clears every register and flag
//   DIN       in   N  instruction word, sampled in T0 when Run=1
//   Run       in   start request, looked at only in T0
//   DbgSel    in   3  register select for DbgData
//   Done      out  pulse in the final step of a legal instruction
//   Err       out  pulse in T1 of an illegal (111) opcode
//   Busy      out  high in every step except T0
//   Z/Neg/C   out  status flags
//   DbgData   out  N  R[DbgSel], combinational
//   BusWires  out  N  internal bus, observation only
module procn #(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] DIN,
    input  logic         Run,
    input  logic [2:0]   DbgSel,
    output logic         Done,
    output logic         Err,
    output logic         Busy,
    output logic         Z,
    output logic         Neg,
    output logic         C,
    output logic [N-1:0] DbgData,
    output logic [N-1:0] BusWires
);

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    state_t       state_q, state_d;
    logic [N-1:0] ir_q, ir_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] g_q, g_d;
    logic [N-1:0] r_q [8];
    logic [N-1:0] r_d [8];
    logic         z_q, z_d, neg_q, neg_d, c_q, c_d;

    // Instruction fields
    logic [2:0]   iii, rx, ry;
    logic         m;
    logic [N-1:0] d_ext, mvt_val, op2;

    assign iii     = ir_q[N-1:N-3];
    assign m       = ir_q[N-4];
    assign rx      = ir_q[N-5:N-7];
    assign ry      = ir_q[2:0];
    assign d_ext   = {7'b0, ir_q[N-8:0]};
    assign mvt_val = {ir_q[7:0], {(N-8){1'b0}}};
    assign op2     = m ? d_ext : r_q[ry];

    // Bus source per step
    logic [N-1:0] bus;

    always_comb begin
        bus = '0;
        unique case (state_q)
            T1: begin
                if (iii == OP_MV)       bus = op2;
                else if (iii == OP_MVT) bus = mvt_val;
                else                    bus = r_q[rx];
            end
            T2:      bus = op2;
            T3:      bus = g_q;
            default: bus = '0;
        endcase
    end

    // ALU: one extra bit so carry (add) and borrow (sub/cmp) fall out of bit N
    logic [N:0]   sum, diff;
    logic [N-1:0] alu_res;
    logic         alu_c;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, bus};
        diff    = {1'b0, a_q} - {1'b0, bus};
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (iii)
            OP_ADD:         begin alu_res = sum[N-1:0];  alu_c = sum[N];  end
            OP_SUB, OP_CMP: begin alu_res = diff[N-1:0]; alu_c = diff[N]; end
            OP_AND:         alu_res = a_q & bus;
            OP_XOR:         alu_res = a_q ^ bus;
            default:        alu_res = '0;
        endcase
    end

    // Next-state / datapath control
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        r_d     = r_q;
        z_d     = z_q;
        neg_d   = neg_q;
        c_d     = c_q;
        unique case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN;
                    state_d = T1;
                end
            end
            T1: begin
                if (iii == OP_MV || iii == OP_MVT) begin
                    r_d[rx] = bus;
                    state_d = T0;
                end else if (iii == OP_ILL) begin
                    state_d = T0;
                end else begin
                    a_d     = bus;
                    state_d = T2;
                end
            end
            T2: begin
                g_d     = alu_res;
                z_d     = (alu_res == '0);
                neg_d   = alu_res[N-1];
                c_d     = alu_c;
                state_d = (iii == OP_CMP) ? T0 : T3;
            end
            T3: begin
                r_d[rx] = bus;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            z_q     <= 1'b0;
            neg_q   <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 8; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            z_q     <= z_d;
            neg_q   <= neg_d;
            c_q     <= c_d;
            r_q     <= r_d;
        end
    end

    // Moore outputs decoded from state and IR
    assign Done = ((state_q == T1) && (iii == OP_MV || iii == OP_MVT)) ||
                  ((state_q == T2) && (iii == OP_CMP)) ||
                  (state_q == T3);
    assign Err      = (state_q == T1) && (iii == OP_ILL);
    assign Busy     = (state_q != T0);
    assign Z        = z_q;
    assign Neg      = neg_q;
    assign C        = c_q;
    assign DbgData  = r_q[DbgSel];
    assign BusWires = bus;

endmodule

// File: tb/tb_procn.sv
`timescale 1ns/1ps
// Bench for procn: three instances (N=16, 12, 32) run the same instruction
// stream in lockstep; each is compared against a per-width instruction-level
// reference model.
module tb_procn;

    logic        clk, rst, run;
    logic [2:0]  dsel;
    logic [15:0] din0, dbg0, bus0;
    logic [11:0] din1, dbg1, bus1;
    logic [31:0] din2, dbg2, bus2;
    logic        done_w [3];
    logic        err_w  [3];
    logic        busy_w [3];
    logic        z_w    [3];
    logic        n_w    [3];
    logic        c_w    [3];

    int checks = 0;
    int fails  = 0;

    // Reference model state per instance
    logic [31:0] mr [3][8];
    logic        mz [3];
    logic        mn [3];
    logic        mc [3];

    procn #(.N(16)) u16 (.Clock(clk), .Reset(rst), .DIN(din0), .Run(run), .DbgSel(dsel),
        .Done(done_w[0]), .Err(err_w[0]), .Busy(busy_w[0]), .Z(z_w[0]), .Neg(n_w[0]),
        .C(c_w[0]), .DbgData(dbg0), .BusWires(bus0));
    procn #(.N(12)) u12 (.Clock(clk), .Reset(rst), .DIN(din1), .Run(run), .DbgSel(dsel),
        .Done(done_w[1]), .Err(err_w[1]), .Busy(busy_w[1]), .Z(z_w[1]), .Neg(n_w[1]),
        .C(c_w[1]), .DbgData(dbg1), .BusWires(bus1));
    procn #(.N(32)) u32 (.Clock(clk), .Reset(rst), .DIN(din2), .Run(run), .DbgSel(dsel),
        .Done(done_w[2]), .Err(err_w[2]), .Busy(busy_w[2]), .Z(z_w[2]), .Neg(n_w[2]),
        .C(c_w[2]), .DbgData(dbg2), .BusWires(bus2));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int wof(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 12 : 32);
    endfunction

    function automatic logic [31:0] get_dbg(input int k);
        if (k == 0) return {16'b0, dbg0};
        if (k == 1) return {20'b0, dbg1};
        return dbg2;
    endfunction

    function automatic logic [31:0] get_bus(input int k);
        if (k == 0) return {16'b0, bus0};
        if (k == 1) return {20'b0, bus1};
        return bus2;
    endfunction

    task automatic set_din(input int k, input logic [31:0] w);
        if (k == 0) din0 = w[15:0];
        else if (k == 1) din1 = w[11:0];
        else din2 = w;
    endtask

    // Field packing for an N-bit word. For mvt the low byte is ORed in as-is,
    // so at N=12 it overlaps rX exactly as the hardware sees it.
    function automatic logic [31:0] enc(input int n, input int op, input int m,
                                        input int rx, input int lo);
        logic [63:0] x, mask;
        mask = (64'd1 << n) - 64'd1;
        x = (64'(op) << (n-3)) | (64'(m) << (n-4)) | (64'(rx) << (n-7));
        if (op == 1)      x |= 64'(lo) & 64'hFF;
        else if (m != 0)  x |= 64'(lo) & ((64'd1 << (n-7)) - 64'd1);
        else              x |= 64'(lo) & 64'd7;
        x &= mask;
        return x[31:0];
    endfunction

    // Executes one instruction on the model; returns step count and the
    // result value (what the bus carries in the writeback step).
    task automatic model_exec(input int k, input logic [31:0] w,
                              output int lat, output logic [31:0] res_o);
        int n, op, rx, ry;
        logic m, flg, wb, cy;
        logic [63:0] wq, mask, a, b, res;
        n    = wof(k);
        mask = (64'd1 << n) - 64'd1;
        wq   = {32'b0, w};
        op   = int'((wq >> (n-3)) & 64'd7);
        m    = ((wq >> (n-4)) & 64'd1) != 0;
        rx   = int'((wq >> (n-7)) & 64'd7);
        ry   = int'(wq & 64'd7);
        a    = {32'b0, mr[k][rx]};
        b    = m ? (wq & ((64'd1 << (n-7)) - 64'd1)) : {32'b0, mr[k][ry]};
        res = 0; flg = 0; wb = 0; cy = 0; lat = 1;
        case (op)
            0: begin res = b; wb = 1; end
            1: begin res = ((wq & 64'hFF) << (n-8)) & mask; wb = 1; end
            2: begin res = a + b; cy = ((res >> n) & 64'd1) != 0; res &= mask;
                     flg = 1; wb = 1; lat = 3; end
            3: begin res = (a - b) & mask; cy = a < b; flg = 1; wb = 1; lat = 3; end
            4: begin res = a & b; flg = 1; wb = 1; lat = 3; end
            5: begin res = a ^ b; flg = 1; wb = 1; lat = 3; end
            6: begin res = (a - b) & mask; cy = a < b; flg = 1; lat = 2; end
            default: lat = 1;
        endcase
        if (flg) begin
            mz[k] = (res == 0);
            mn[k] = ((res >> (n-1)) & 64'd1) != 0;
            mc[k] = cy;
        end
        if (wb) mr[k][rx] = res[31:0];
        res_o = res[31:0];
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++) mr[k][r] = '0;
            mz[k] = 0; mn[k] = 0; mc[k] = 0;
        end
    endtask

    // Issues one instruction to all three instances starting in T0 (called at
    // a negedge), checks every step, then checks registers and flags in T0.
    task automatic run_instr(input int op, input int m, input int rx, input int lo,
                             input bit hold);
        int lat;
        logic [31:0] w, expb [3];
        for (int k = 0; k < 3; k++) begin
            w = enc(wof(k), op, m, rx, lo);
            set_din(k, w);
            model_exec(k, w, lat, expb[k]);
        end
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 1'b0) begin
                fails++; $display("FAIL t0_busy N=%0d op=%0d got=%b want=0", wof(k), op, busy_w[k]);
            end
        end
        @(posedge clk); @(negedge clk);
        if (!hold) run = 1'b0;
        for (int k = 0; k < 3; k++) set_din(k, $urandom);
        for (int cyc = 1; cyc <= lat; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_w[k] !== (cyc == lat && op != 7) || err_w[k] !== (cyc == 1 && op == 7) ||
                    busy_w[k] !== 1'b1) begin
                    fails++;
                    $display("FAIL step N=%0d op=%0d cyc=%0d got done=%b err=%b busy=%b want done=%b err=%b busy=1",
                             wof(k), op, cyc, done_w[k], err_w[k], busy_w[k],
                             (cyc == lat && op != 7), (cyc == 1 && op == 7));
                end
                if (cyc == lat && op <= 5) begin
                    checks++;
                    if (get_bus(k) !== expb[k]) begin
                        fails++; $display("FAIL bus N=%0d op=%0d got=%h want=%h", wof(k), op, get_bus(k), expb[k]);
                    end
                end
            end
            if (cyc < lat) begin @(posedge clk); @(negedge clk); end
        end
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || err_w[k] !== 1'b0 ||
                z_w[k] !== mz[k] || n_w[k] !== mn[k] || c_w[k] !== mc[k]) begin
                fails++;
                $display("FAIL post N=%0d op=%0d got busy=%b done=%b err=%b znc=%b%b%b want busy=0 done=0 err=0 znc=%b%b%b",
                         wof(k), op, busy_w[k], done_w[k], err_w[k], z_w[k], n_w[k], c_w[k], mz[k], mn[k], mc[k]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            dsel = 3'(r); #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (get_dbg(k) !== mr[k][r]) begin
                    fails++; $display("FAIL reg N=%0d op=%0d r%0d got=%h want=%h", wof(k), op, r, get_dbg(k), mr[k][r]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; dsel = 3'd0;
        for (int k = 0; k < 3; k++) set_din(k, '1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (done_w[k] !== 0 || err_w[k] !== 0 || busy_w[k] !== 0 ||
                z_w[k] !== 0 || n_w[k] !== 0 || c_w[k] !== 0 || get_dbg(k) !== 0) begin
                fails++;
                $display("FAIL reset N=%0d got done=%b err=%b busy=%b znc=%b%b%b r0=%h want all 0",
                         wof(k), done_w[k], err_w[k], busy_w[k], z_w[k], n_w[k], c_w[k], get_dbg(k));
            end
        end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    // Directed sequence; fixed expected values are checked on the N=16 instance.
    task automatic test_directed();
        run_instr(0, 1, 0, 5, 0);          // mv r0,#5
        dsel = 3'd0; #1;
        checks++;
        if (dbg0 !== 16'h0005 || z_w[0] !== 0 || n_w[0] !== 0 || c_w[0] !== 0) begin
            fails++; $display("FAIL mv16 got r0=%h znc=%b%b%b want 0005 000", dbg0, z_w[0], n_w[0], c_w[0]);
        end
        run_instr(1, 1, 1, 8'hA5, 0);      // mvt r1,#A5
        dsel = 3'd1; #1;
        checks++;
        if (dbg0 !== 16'hA500) begin
            fails++; $display("FAIL mvt16 got r1=%h want a500", dbg0);
        end
        run_instr(2, 0, 0, 1, 0);          // add r0,r1
        dsel = 3'd0; #1;
        checks++;
        if (dbg0 !== 16'hA505 || z_w[0] !== 0 || n_w[0] !== 1 || c_w[0] !== 0) begin
            fails++; $display("FAIL add16 got r0=%h znc=%b%b%b want a505 010", dbg0, z_w[0], n_w[0], c_w[0]);
        end
        run_instr(3, 1, 2, 1, 0);          // sub r2,#1 (r2=0)
        dsel = 3'd2; #1;
        checks++;
        if (dbg0 !== 16'hFFFF || z_w[0] !== 0 || n_w[0] !== 1 || c_w[0] !== 1) begin
            fails++; $display("FAIL sub16 got r2=%h znc=%b%b%b want ffff 011", dbg0, z_w[0], n_w[0], c_w[0]);
        end
        run_instr(2, 1, 2, 1, 0);          // add r2,#1 -> wraps to 0
        dsel = 3'd2; #1;
        checks++;
        if (dbg0 !== 16'h0000 || z_w[0] !== 1 || c_w[0] !== 1) begin
            fails++; $display("FAIL addwrap16 got r2=%h z=%b c=%b want 0000 1 1", dbg0, z_w[0], c_w[0]);
        end
        run_instr(6, 0, 0, 0, 0);          // cmp r0,r0
        dsel = 3'd0; #1;
        checks++;
        if (dbg0 !== 16'hA505 || z_w[0] !== 1 || c_w[0] !== 0) begin
            fails++; $display("FAIL cmp16 got r0=%h z=%b c=%b want a505 1 0", dbg0, z_w[0], c_w[0]);
        end
        run_instr(5, 0, 0, 0, 0);          // xor r0,r0
        dsel = 3'd0; #1;
        checks++;
        if (dbg0 !== 16'h0000 || z_w[0] !== 1 || c_w[0] !== 0) begin
            fails++; $display("FAIL xor16 got r0=%h z=%b c=%b want 0000 1 0", dbg0, z_w[0], c_w[0]);
        end
    endtask

    task automatic test_illegal();
        run_instr(2, 1, 3, 9, 0);          // set flags to something nonzero-ish first
        run_instr(7, 0, 0, 0, 0);          // 0xE000 at N=16
        run_instr(7, 1, 5, 31, 0);
    endtask

    task automatic test_back_to_back();
        run_instr(0, 1, 4, 3, 1);
        run_instr(2, 0, 4, 4, 1);
        run_instr(6, 1, 4, 6, 1);
        run_instr(1, 0, 6, 8'h81, 1);
        run_instr(4, 0, 4, 6, 1);
        run = 1'b0;
    endtask

    task automatic test_random();
        int op, m, rx, lo;
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 7);
            m  = $urandom_range(0, 1);
            rx = $urandom_range(0, 7);
            lo = (op == 1) ? $urandom_range(0, 255) : (m ? $urandom : $urandom_range(0, 7));
            run_instr(op, m, rx, lo, $urandom_range(0, 1));
        end
        run = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        int lat;
        logic [31:0] dummy;
        run_instr(0, 1, 0, 7, 0);
        run_instr(0, 1, 1, 9, 0);
        for (int k = 0; k < 3; k++) begin
            w = enc(wof(k), 2, 0, 0, 1);   // add r0,r1 -- aborted, model untouched
            set_din(k, w);
        end
        run = 1'b1;
        @(posedge clk); @(negedge clk);    // T1
        run = 1'b0;
        @(posedge clk); @(negedge clk);    // T2
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
                fails++; $display("FAIL pre_abort N=%0d got busy=%b done=%b want 1 0", wof(k), busy_w[k], done_w[k]);
            end
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 0 || done_w[k] !== 0 || err_w[k] !== 0 ||
                z_w[k] !== 0 || n_w[k] !== 0 || c_w[k] !== 0) begin
                fails++;
                $display("FAIL abort N=%0d got busy=%b done=%b err=%b znc=%b%b%b want all 0",
                         wof(k), busy_w[k], done_w[k], err_w[k], z_w[k], n_w[k], c_w[k]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            dsel = 3'(r); #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (get_dbg(k) !== 0) begin
                    fails++; $display("FAIL abort_reg N=%0d r%0d got=%h want=0", wof(k), r, get_dbg(k));
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] !== 1'b0) begin
                fails++; $display("FAIL idle_after_reset N=%0d got busy=%b want 0", wof(k), busy_w[k]);
            end
        end
        run_instr(0, 1, 2, 11, 0);
        lat = 0; dummy = '0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
